// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction memory X/Y port plus the {instruction, pc} valid/ready channel to decode.
interface instruction_fetch_unit_if #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 2*ADDR_BITS+2
);
  logic [ADDR_BITS-1:0]  Mem_X_addr;
  logic [ADDR_BITS-1:0]  Mem_Y_addr;
  logic                  Mem_WriteEnable;
  logic [DATA_WIDTH-1:0] Mem_Data_in;
  logic [DATA_WIDTH-1:0] Mem_Data_out;
  logic                  Instr_valid;
  logic                  Instr_ready;
  logic [DATA_WIDTH-1:0] Instr_data;
  logic [PC_WIDTH-1:0]   Instr_pc;

  modport master (
    output Mem_X_addr, Mem_Y_addr, Mem_WriteEnable, Mem_Data_in,
    input  Mem_Data_out,
    output Instr_valid, Instr_data, Instr_pc,
    input  Instr_ready
  );

  modport slave (
    input  Mem_X_addr, Mem_Y_addr, Mem_WriteEnable, Mem_Data_in,
    output Mem_Data_out,
    input  Instr_valid, Instr_data, Instr_pc,
    output Instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC holder / fetch issuer with a BUF_DEPTH skid FIFO; issue->valid is 2 cycles, 1 instr/cycle sustained.
// Credit-style issue never overruns the FIFO under decode backpressure; FETCH_MISALIGN_CHECK_EN adds Fetch_fault.
module instruction_fetch_unit #(
  parameter int                  ADDR_BITS  = 4,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 2*ADDR_BITS+2,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  BUF_DEPTH  = 2
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Fetch_en,
  input  logic                Redirect_valid,
  input  logic [PC_WIDTH-1:0] Redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                Fetch_fault,
`endif
  instruction_fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int PW = $clog2(BUF_DEPTH);

  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   inflight_pc;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_dat [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   buf_pc  [BUF_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         occ;
  logic [CW:0]           pending;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic                  fault_blk;
  logic                  load_pc;
  logic [3:0]            unused_lo;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q;
  assign fault_blk   = fault_q;
  assign load_pc     = (Redirect_pc[1:0] == 2'b00);
  assign Fetch_fault = fault_q;
`else
  assign fault_blk = 1'b0;
  assign load_pc   = 1'b1;
`endif

  assign unused_lo = {Redirect_pc[1:0], pc[1:0]};

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.Mem_X_addr      = pc[PC_WIDTH-1:ADDR_BITS+2];
  assign bus.Mem_Y_addr      = pc[ADDR_BITS+1:2];
  assign bus.Mem_WriteEnable = 1'b0;
  assign bus.Mem_Data_in     = '0;

  assign bus.Instr_valid = (occ != '0);
  assign bus.Instr_data  = buf_dat[rd_ptr];
  assign bus.Instr_pc    = buf_pc[rd_ptr];

  assign pop  = bus.Instr_valid & bus.Instr_ready;
  assign push = inflight & ~Redirect_valid;

  // Entries held plus the read still in the memory pipe, less the one leaving this cycle.
  assign pending = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue   = Fetch_en & ~Redirect_valid & ~fault_blk & (pending < (CW+1)'(BUF_DEPTH));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc          <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_dat[i] <= '0;
        buf_pc[i]  <= '0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else if (Redirect_valid) begin
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      if (load_pc) begin
        pc <= {Redirect_pc[PC_WIDTH-1:2], 2'b00};
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (!load_pc) begin
        fault_q <= 1'b1;
      end
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_WIDTH'(4);
      end
      if (push) begin
        buf_dat[wr_ptr] <= bus.Mem_Data_out;
        buf_pc[wr_ptr]  <= inflight_pc;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  a_no_push_when_full: assert property (@(posedge Clock) disable iff (!Reset_n)
    !(push && !pop && (occ == CW'(BUF_DEPTH))));

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sits directly upstream of the instruction memory and downstream of the branch/redirect logic.
- Holds the PC and splits it into the memory's X/Y row/column addresses.
- Absorbs the memory's one-cycle registered read latency.
- Delivers {instruction, pc} pairs to decode over a valid/ready handshake, using a small skid buffer so decode backpressure never loses a fetched word.

Parameters:
ADDR_BITS, 4, width of each of X_addr and Y_addr; memory holds 2^(2*ADDR_BITS) words
DATA_WIDTH, 32, instruction width
PC_WIDTH, 2*ADDR_BITS+2, byte-address PC width; bits [1:0] are always 0
RESET_PC, 0, PC value loaded on reset
BUF_DEPTH, 2, output buffer entries; must be >= 2

Ports:
Clock  in  1  single clock; all state updates on posedge
Reset_n  in  1  asynchronous, active-low reset
Fetch_en  in  1  1 = allowed to issue new fetches
Redirect_valid  in  1  load Redirect_pc and flush
Redirect_pc  in  PC_WIDTH  new fetch address
Mem_X_addr  out  ADDR_BITS  equals pc[PC_WIDTH-1:ADDR_BITS+2]
Mem_Y_addr  out  ADDR_BITS  equals pc[ADDR_BITS+1:2]
Mem_WriteEnable  out  1  tied 0
Mem_Data_in  out  DATA_WIDTH  tied 0
Mem_Data_out  in  DATA_WIDTH  memory read data, valid the cycle after its address is presented
Instr_valid  out  1  buffer head valid
Instr_ready  in  1  decode accepts
Instr_data  out  DATA_WIDTH  instruction at buffer head
Instr_pc  out  PC_WIDTH  byte PC of Instr_data

Behaviour:
- Interface: one clock (Clock). Reset (Reset_n) is asynchronous, active-low.
- Reset (async, while Reset_n=0):
  - pc=RESET_PC, inflight=0, buffer empty.
  - Instr_valid=0, Instr_data=0, Instr_pc=0.
  - Reset asserted mid-operation clears all state immediately, including in-flight reads.
- Mem_X_addr/Mem_Y_addr are driven combinationally from the pc register every cycle.
- Issue condition: Fetch_en & !Redirect_valid & (occ + inflight - pop) < BUF_DEPTH, where pop = Instr_valid & Instr_ready.
- On issue, at the edge: inflight<=1, inflight_pc<=pc, pc<=pc+4.
  - PC wraps modulo 2^PC_WIDTH, so the last word is followed by address 0.
- With no issue, inflight<=0 at the edge.
- Capture: when inflight=1, Mem_Data_out is sampled at the end of that cycle and {Mem_Data_out, inflight_pc} is pushed into the buffer. When inflight=0, Mem_Data_out is ignored, since it may be X.
- Latency: issue in cycle N, Mem_Data_out valid in N+1, Instr_valid=1 in N+2.
- Throughput: 1 instr/cycle sustained when Instr_ready=1.
- Buffer is a FIFO:
  - Simultaneous push and pop leaves occ unchanged.
  - Push when full never occurs; this is guaranteed by the issue rule, and an assertion flags any violation.
  - Empty: Instr_valid=0.
- Handshake: while Instr_valid=1 & Instr_ready=0, Instr_data and Instr_pc hold stable. Instr_valid never drops without a pop, except on redirect or reset.
- Redirect (cycle R, Redirect_valid=1):
  - At the edge: pc<=Redirect_pc, buffer cleared, inflight<=0. Data returning in R+1 is discarded.
  - No issue in R.
  - A handshake completing in cycle R counts as delivered.
  - Instr_valid=0 in R+1. The first new instruction is issued in R+1 and valid in R+3.
  - Redirect has priority over Fetch_en, push and pop.
- Fetch_en=0: no new issues; an outstanding inflight read still completes into the buffer and the buffer drains normally.
- Redirect_pc[1:0] is ignored (forced to 00) unless the optional feature is compiled in.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output Fetch_fault (1 bit, reset 0).
  - A redirect with Redirect_pc[1:0]!=0 sets Fetch_fault sticky (cleared only by reset), flushes as usual, and does not load pc.
  - Issue is inhibited while Fetch_fault=1.
- Undefined: no Fetch_fault port; the low bits are silently forced to 00.

Test Plan:
- Preload mem word i = 0xA000_0000+i, Fetch_en=1, Instr_ready=1 from reset -> Instr_valid first high 2 cycles after Reset_n rises; sequential pc 0x0,0x4,0x8… with data 0xA0000000,0xA0000001… one per cycle.
- Streaming, then Instr_ready=0 for 5 cycles, then 1 -> Instr_data/Instr_pc frozen while stalled; no word skipped or duplicated; at most BUF_DEPTH entries held; order preserved.
- Redirect_valid=1 with Redirect_pc=0x40 mid-stream -> Instr_valid=0 the next cycle; next delivered pair is {mem[16], 0x40} exactly 3 cycles after the redirect cycle; no stale pc delivered.
- pc=0x3FC with ADDR_BITS=4 -> delivered pcs 0x3FC then 0x000; Mem_X_addr/Mem_Y_addr go 15/15 then 0/0.
- Reset_n pulled low mid-stream with buffer full -> Instr_valid=0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
- FETCH_MISALIGN_CHECK_EN defined, Redirect_pc=0x42 -> Fetch_fault=1 the next cycle, Instr_valid stays 0, pc unchanged; without the macro -> fetch resumes at 0x40.
